// File: rtl/y_cpu_pkg.sv
// y_cpu_pkg: opcode constants and PC-unit FSM states shared by the PC unit and its next-PC calculator
package y_cpu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_e;
endpackage

// File: rtl/y_npc_calc.sv
// y_npc_calc: combinational pc+4, branch/jump target and taken decision for the instruction at pc
module y_npc_calc
    import y_cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [25:0] j_target,
    output logic [31:0] pcp4,
    output logic [31:0] target,
    output logic        taken
);
    // jumps keep the pcp4 region nibble; branches are pcp4-relative word offsets
    always_comb begin
        pcp4   = pc + 32'd4;
        target = (op == OP_J) ? {pcp4[31:28], j_target, 2'b00} : pcp4 + (imm << 2);
        taken  = (op == OP_J) | ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
    end
endmodule

// File: rtl/y_pc_unit.sv
// y_pc_unit: fetch PC sequencer with IDLE/RUN/HALT FSM and retire counter; Y_PC_DELAY_SLOT_EN adds one branch delay slot
module y_pc_unit
    import y_cpu_pkg::*;
#(
    parameter logic [31:0] ENTRY_PC = 32'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [25:0] jTarget,
    output logic [31:0] pc,
    output logic [31:0] pcp4,
    output logic        pc_valid,
    output logic        redirect,
    output logic [31:0] icount,
    output logic        halted
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] icount_q, icount_d;
    logic [31:0] target;
    logic        taken;
`ifdef Y_PC_DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
`endif

    y_npc_calc u_npc (
        .pc       (pc_q),
        .op       (op),
        .zero     (zero),
        .imm      (imm),
        .j_target (jTarget),
        .pcp4     (pcp4),
        .target   (target),
        .taken    (taken)
    );

    // next state: halt wins over stall, and the instruction seen with halt does not retire
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        redirect = 1'b0;
`ifdef Y_PC_DELAY_SLOT_EN
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
`endif
        if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            pc_d    = ENTRY_PC;
        end else if (state_q == ST_RUN && halt) begin
            state_d = ST_HALT;
        end else if (state_q == ST_RUN && !stall) begin
            icount_d = icount_q + 32'd1;
`ifdef Y_PC_DELAY_SLOT_EN
            if (pend_q) begin
                pc_d     = pend_pc_q;
                pend_d   = 1'b0;
                redirect = 1'b1;
            end else begin
                pc_d      = pcp4;
                pend_d    = taken;
                pend_pc_d = taken ? target : pend_pc_q;
            end
`else
            pc_d     = taken ? target : pcp4;
            redirect = taken;
`endif
        end
    end

    // state, PC and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= ENTRY_PC;
            icount_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
        end
    end

`ifdef Y_PC_DELAY_SLOT_EN
    // pending target captured by a taken transfer, consumed after the delay slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end
`endif

    assign pc       = pc_q;
    assign icount   = icount_q;
    assign pc_valid = (state_q == ST_RUN);
    assign halted   = (state_q == ST_HALT);
endmodule

// File: tb/tb_y_pc_unit.sv
// tb_y_pc_unit: directed self-checking bench for y_pc_unit (both Y_PC_DELAY_SLOT_EN builds)
module tb_y_pc_unit;
    logic        clk, rst_n, stall, halt, zero, pc_valid, redirect, halted;
    logic [5:0]  op;
    logic [31:0] imm, pc, pcp4, icount;
    logic [25:0] jt;
    int passed = 0;
    int total  = 0;

    y_pc_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .halt     (halt),
        .op       (op),
        .zero     (zero),
        .imm      (imm),
        .jTarget  (jt),
        .pc       (pc),
        .pcp4     (pcp4),
        .pc_valid (pc_valid),
        .redirect (redirect),
        .icount   (icount),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; halt = 1'b0; op = 6'd0; zero = 1'b0; imm = 32'd0; jt = 26'd0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'd128);
        chk("rst_icount", icount, 32'd0);
        chk("rst_valid", {31'd0, pc_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_pc", pc, 32'd128);
        chk("idle_valid", {31'd0, pc_valid}, 32'd0);
        step();
        chk("run0_pc", pc, 32'd128);
        chk("run0_icount", icount, 32'd0);
        chk("run0_valid", {31'd0, pc_valid}, 32'd1);
        step();
        chk("run1_pc", pc, 32'd132);
        chk("run1_icount", icount, 32'd1);
        chk("run1_pcp4", pcp4, 32'd136);
        step();
        chk("run2_pc", pc, 32'd136);
        chk("run2_icount", icount, 32'd2);
`ifdef Y_PC_DELAY_SLOT_EN
        op = 6'h04; zero = 1'b1; imm = 32'd15;
        #1;
        chk("ds_beq_redirect", {31'd0, redirect}, 32'd0);
        step();
        chk("ds_slot_pc", pc, 32'd140);
        chk("ds_slot_icount", icount, 32'd3);
        op = 6'h02; jt = 26'd0; zero = 1'b0;
        #1;
        chk("ds_slot_redirect", {31'd0, redirect}, 32'd1);
        step();
        chk("ds_target_pc", pc, 32'd200);
        chk("ds_target_icount", icount, 32'd4);
        op = 6'h00;
        step();
        chk("ds_after_pc", pc, 32'd204);
`else
        op = 6'h04; zero = 1'b1; imm = 32'hFFFF_FFFE;
        #1;
        chk("beq_t_redirect", {31'd0, redirect}, 32'd1);
        step();
        chk("beq_t_pc", pc, 32'd132);
        chk("beq_t_icount", icount, 32'd3);
        op = 6'h00;
        #1;
        chk("seq_redirect", {31'd0, redirect}, 32'd0);
        step();
        chk("seq_pc", pc, 32'd136);
        op = 6'h04; zero = 1'b0;
        #1;
        chk("beq_nt_redirect", {31'd0, redirect}, 32'd0);
        step();
        chk("beq_nt_pc", pc, 32'd140);
        chk("beq_nt_icount", icount, 32'd5);
        zero = 1'b1; imm = 32'h03FF_FFFC;
        step();
        chk("beq_far_pc", pc, 32'h1000_0080);
        op = 6'h02; jt = 26'h000_0020;
        #1;
        chk("j_redirect", {31'd0, redirect}, 32'd1);
        chk("j_pcp4", pcp4, 32'h1000_0084);
        step();
        chk("j_pc", pc, 32'h1000_0080);
        chk("j_icount", icount, 32'd7);
        op = 6'h05; zero = 1'b0; imm = 32'd1;
        #1;
        chk("bne_t_redirect", {31'd0, redirect}, 32'd1);
        step();
        chk("bne_t_pc", pc, 32'h1000_0088);
        zero = 1'b1;
        #1;
        chk("bne_nt_redirect", {31'd0, redirect}, 32'd0);
`endif
        op = 6'h00; zero = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc, 32'd128);
        chk("async_rst_icount", icount, 32'd0);
        chk("async_rst_valid", {31'd0, pc_valid}, 32'd0);
        chk("async_rst_redirect", {31'd0, redirect}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        chk("rerun_pc", pc, 32'd140);
        chk("rerun_icount", icount, 32'd3);
        stall = 1'b1; op = 6'h02; jt = 26'h0;
        #1;
        chk("stall_redirect", {31'd0, redirect}, 32'd0);
        repeat (3) step();
        chk("stall_pc", pc, 32'd140);
        chk("stall_icount", icount, 32'd3);
        halt = 1'b1;
        step();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, pc_valid}, 32'd0);
        chk("halt_pc", pc, 32'd140);
        chk("halt_icount", icount, 32'd3);
        halt = 1'b0; stall = 1'b0;
        repeat (2) step();
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        chk("halt_frozen_pc", pc, 32'd140);
        chk("halt_redirect", {31'd0, redirect}, 32'd0);
        op = 6'h00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("wrap_run_pc", pc, 32'd128);
        force dut.icount_q = 32'hFFFF_FFFF;
        #1;
        release dut.icount_q;
        #1;
        chk("wrap_preset", icount, 32'hFFFF_FFFF);
        step();
        chk("wrap_icount", icount, 32'd0);
        chk("wrap_pc", pc, 32'd132);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
